wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//   Write-back arbiter directly upstream of the register file: merges the in-order MEM/WB write stream and
//   results from long-latency units (divider, etc.) onto the single regfile write port (we/waddr/wdata).
//   Long-latency results are buffered in a small FIFO that drains only when the pipeline is not writing.
//   A pending-write scoreboard (pend_o) lets ID stall on RAW/WAW against in-flight long-latency results.
// PARAMETERS
//   ADDR_W      5   register address width (32 registers; register 0 is hard-wired zero)
//   DATA_W      32  register data width
//   FIFO_DEPTH  4   long-latency result buffer entries (power of two, >= 2)
//   STARVE_MAX  8   consecutive blocked-drain cycles before stall_req_o asserts
// PORTS
//   clk             in   1            clock, all state on rising edge
//   rst             in   1            asynchronous active-low reset
//   pipe_we_i       in   1            MEM/WB write enable
//   pipe_waddr_i    in   ADDR_W       MEM/WB destination register
//   pipe_wdata_i    in   DATA_W       MEM/WB write data
//   lu_issue_i      in   1            long-latency op issued this cycle (from ID/EX)
//   lu_issue_addr_i in   ADDR_W       destination of the issued long-latency op
//   lu_valid_i      in   1            long-latency result valid
//   lu_ready_o      out  1            FIFO can accept a result (registered)
//   lu_waddr_i      in   ADDR_W       long-latency result destination
//   lu_wdata_i      in   DATA_W       long-latency result data
//   we_o            out  1            regfile write enable
//   waddr_o         out  ADDR_W       regfile write address
//   wdata_o         out  DATA_W       regfile write data
//   pend_o          out  2**ADDR_W    per-register pending long-latency write bitmask
//   stall_req_o     out  1            request pipeline freeze so the FIFO can drain (registered)
// BEHAVIOUR
//   Reset (rst=0, async): FIFO pointers/count=0, pend_o=0, starve counter=0, stall_req_o=0, lu_ready_o=0,
//     we_o=0 while rst=0. First edge after release: lu_ready_o=1.
//   Pipe path: combinational, zero latency. pipe_we_i=1 and pipe_waddr_i!=0 -> we_o=1, waddr_o/wdata_o=pipe.
//     Pipe always has priority; a pipe write is never dropped or delayed, even with stall_req_o=1.
//   Pipe write with pipe_waddr_i=0 counts as no write (FIFO may drain that cycle).
//   FIFO push: lu_valid_i & lu_ready_o at rising edge. Entries with lu_waddr_i=0 are accepted then discarded on pop.
//   FIFO pop: count>0 and no effective pipe write -> we_o=1, waddr_o/wdata_o = head entry (combinational from head);
//     pointer advances at that edge. Minimum push-to-regfile latency: 1 cycle (no same-cycle bypass).
//   Simultaneous push and pop: count unchanged. lu_ready_o = (next count < FIFO_DEPTH); full -> ready=0,
//     no push accepted even if a pop occurs that cycle (ready reflects registered state).
//   Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
//   No write: we_o=0, waddr_o=0, wdata_o=0.
//   Scoreboard: lu_issue_i & addr!=0 sets pend[addr] next edge; FIFO pop writing addr clears pend[addr].
//     Set and clear of same bit in one cycle -> set wins (stays 1). pend_o[0] always 0. Pipe writes never
//     touch pend_o.
//   Starvation: counter increments each cycle count>0 and pop blocked by pipe; clears on any pop or count=0.
//     Counter reaching STARVE_MAX -> stall_req_o=1 next edge; held until the first pop, cleared at that edge.
//     Pipeline control inserts bubbles (pipe_we_i=0) while stall_req_o=1.
//   Reset mid-operation: FIFO contents and pending bits are discarded; no write issued during reset.
// TESTING
//   1 Reset: hold rst=0 with lu_valid_i=1 -> we_o=0, lu_ready_o=0, pend_o=0; release -> lu_ready_o=1 next edge.
//   2 Pipe write waddr=5 data=0xDEADBEEF, FIFO empty -> same cycle we_o=1, waddr_o=5, wdata_o=0xDEADBEEF.
//   3 Issue addr 8; 3 cycles later push (8,0x00001234), no pipe -> next cycle write 8/0x1234; pend_o[8] 1->0 after.
//   4 Pipe writes every cycle, push 4 results -> lu_ready_o=0 after 4th accept, count=4, no lu write emitted.
//   5 Continue 4 with STARVE_MAX=8 -> stall_req_o=1 after 8 blocked cycles; drop pipe_we_i -> pops in order, clears.
//   6 Issue addr 9 same cycle as pop writing addr 9 -> pend_o[9] stays 1; push waddr=0 -> accepted, we_o stays 0.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus bundle: pipe write, long-latency result
// stream, regfile write port and hazard/stall status.
interface wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic                 pipe_we_i;
  logic [ADDR_W-1:0]    pipe_waddr_i;
  logic [DATA_W-1:0]    pipe_wdata_i;
  logic                 lu_issue_i;
  logic [ADDR_W-1:0]    lu_issue_addr_i;
  logic                 lu_valid_i;
  logic                 lu_ready_o;
  logic [ADDR_W-1:0]    lu_waddr_i;
  logic [DATA_W-1:0]    lu_wdata_i;
  logic                 we_o;
  logic [ADDR_W-1:0]    waddr_o;
  logic [DATA_W-1:0]    wdata_o;
  logic [2**ADDR_W-1:0] pend_o;
  logic                 stall_req_o;

  modport slave (
    input  pipe_we_i, pipe_waddr_i, pipe_wdata_i,
    input  lu_issue_i, lu_issue_addr_i,
    input  lu_valid_i, lu_waddr_i, lu_wdata_i,
    output lu_ready_o,
    output we_o, waddr_o, wdata_o,
    output pend_o, stall_req_o
  );

  modport master (
    output pipe_we_i, pipe_waddr_i, pipe_wdata_i,
    output lu_issue_i, lu_issue_addr_i,
    output lu_valid_i, lu_waddr_i, lu_wdata_i,
    input  lu_ready_o,
    input  we_o, waddr_o, wdata_o,
    input  pend_o, stall_req_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: pipe writes win the regfile port, long-latency
// results queue in a FIFO and drain on idle pipe cycles.
module wb_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SV_W  = $clog2(STARVE_MAX + 1);
  localparam int NREG  = 2 ** ADDR_W;

  logic [ADDR_W-1:0] addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] data_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [SV_W-1:0]  starve_q, starve_d;
  logic             stall_q, stall_d;
  logic [NREG-1:0]  pend_q, pend_d;

  logic              pipe_wr;
  logic              push;
  logic              pop;
  logic              blocked;
  logic              lu_wr;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

  // Gating with rst keeps the write port quiet while reset is held.
  assign pipe_wr = rst & bus.pipe_we_i
                 & (bus.pipe_waddr_i != '0);
  assign push    = bus.lu_valid_i & ready_q;
  assign pop     = (cnt_q != '0) & ~pipe_wr;
  assign blocked = (cnt_q != '0) & pipe_wr;
  assign lu_wr   = pop & (head_addr != '0);

  always_comb begin
    bus.we_o    = 1'b0;
    bus.waddr_o = '0;
    bus.wdata_o = '0;
    if (pipe_wr) begin
      bus.we_o    = 1'b1;
      bus.waddr_o = bus.pipe_waddr_i;
      bus.wdata_o = bus.pipe_wdata_i;
    end else if (lu_wr) begin
      bus.we_o    = 1'b1;
      bus.waddr_o = head_addr;
      bus.wdata_o = head_data;
    end
  end

  assign bus.lu_ready_o  = ready_q;
  assign bus.stall_req_o = stall_q;
  assign bus.pend_o      = pend_q;

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(push) - CNT_W'(pop);
    ready_d = cnt_d < CNT_W'(FIFO_DEPTH);
  end

  // Set after clear so an issue racing its own retirement stays pending.
  always_comb begin
    pend_d = pend_q;
    if (lu_wr)
      pend_d[head_addr] = 1'b0;
    if (bus.lu_issue_i && bus.lu_issue_addr_i != '0)
      pend_d[bus.lu_issue_addr_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    starve_d = '0;
    if (blocked) begin
      if (starve_q == SV_W'(STARVE_MAX))
        starve_d = starve_q;
      else
        starve_d = starve_q + SV_W'(1);
    end
    stall_d = stall_q | (starve_d == SV_W'(STARVE_MAX));
    if (pop)
      stall_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      pend_q   <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      pend_q   <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.lu_waddr_i;
      data_q[wr_ptr_q] <= bus.lu_wdata_i;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-level reference model predicts
// each cycle's regfile write and status; a negedge monitor compares.
module tb_wb_arbiter;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SMAX  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  wb_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit        we;
    bit [4:0]  a;
    bit [31:0] d;
    bit        rdy;
    bit        stl;
    bit [31:0] pend;
  } exp_t;

  typedef struct {
    bit [4:0]  a;
    bit [31:0] d;
  } ent_t;

  exp_t exp_q[$];
  ent_t m_fifo[$];
  bit [31:0] m_pend;
  bit        m_rdy;
  bit        m_stall;
  int        m_starve;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s @%0t: got %h, expected %h", n, $time, act, req);
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      chk("we_o", 32'(bus.we_o), 32'(me.we));
      chk("waddr_o", 32'(bus.waddr_o), 32'(me.a));
      chk("wdata_o", bus.wdata_o, me.d);
      chk("lu_ready_o", 32'(bus.lu_ready_o), 32'(me.rdy));
      chk("stall_req_o", 32'(bus.stall_req_o), 32'(me.stl));
      chk("pend_o", bus.pend_o, me.pend);
    end
  end

  // Drive one cycle, predict what this cycle shows, then advance the model.
  task automatic cycle(input bit pwe, input bit [4:0] pa,
                       input bit [31:0] pd, input bit iss,
                       input bit [4:0] ia, input bit lv,
                       input bit [4:0] la, input bit [31:0] ld);
    exp_t e;
    ent_t ent;
    bit   pipe_w, popped, blk;
    bus.pipe_we_i       = pwe;
    bus.pipe_waddr_i    = pa;
    bus.pipe_wdata_i    = pd;
    bus.lu_issue_i      = iss;
    bus.lu_issue_addr_i = ia;
    bus.lu_valid_i      = lv;
    bus.lu_waddr_i      = la;
    bus.lu_wdata_i      = ld;
    e.we = 0; e.a = 0; e.d = 0;
    e.rdy = 0; e.stl = 0; e.pend = 0;
    if (!rst) begin
      exp_q.push_back(e);
      m_fifo.delete();
      m_pend = 0; m_rdy = 0;
      m_stall = 0; m_starve = 0;
    end else begin
      pipe_w = pwe && pa != 0;
      if (pipe_w) begin
        e.we = 1; e.a = pa; e.d = pd;
      end else if (m_fifo.size() > 0 && m_fifo[0].a != 0) begin
        e.we = 1; e.a = m_fifo[0].a; e.d = m_fifo[0].d;
      end
      e.rdy = m_rdy; e.stl = m_stall; e.pend = m_pend;
      exp_q.push_back(e);
      blk    = pipe_w && m_fifo.size() > 0;
      popped = !pipe_w && m_fifo.size() > 0;
      if (popped) begin
        ent = m_fifo.pop_front();
        if (ent.a != 0) m_pend[ent.a] = 0;
      end
      if (lv && m_rdy) begin
        ent.a = la; ent.d = ld;
        m_fifo.push_back(ent);
      end
      if (iss && ia != 0) m_pend[ia] = 1;
      m_starve = blk ? ((m_starve >= SMAX) ? SMAX : m_starve + 1) : 0;
      m_stall  = popped ? 0 : (m_stall || m_starve >= SMAX);
      m_rdy    = m_fifo.size() < DEPTH;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  bit        pwe, iss, lv;
  bit [4:0]  pa, ia, la;
  bit [31:0] pd, ld;

  initial begin
    bus.pipe_we_i = 0; bus.pipe_waddr_i = 0; bus.pipe_wdata_i = 0;
    bus.lu_issue_i = 0; bus.lu_issue_addr_i = 0;
    bus.lu_valid_i = 0; bus.lu_waddr_i = 0; bus.lu_wdata_i = 0;
    m_pend = 0; m_rdy = 0; m_stall = 0; m_starve = 0;
    @(posedge clk);
    #1;

    // Reset held with traffic present
    repeat (3) cycle(1, 3, 32'h11, 1, 4, 1, 3, 32'h1);
    rst = 1'b1;
    idle();
    idle();

    // Pipe write with empty FIFO
    cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);

    // Issue, later result, drain and pend clear
    cycle(0, 0, 0, 1, 8, 0, 0, 0);
    repeat (3) idle();
    cycle(0, 0, 0, 0, 0, 1, 8, 32'h00001234);
    idle();
    idle();

    // Fill FIFO behind continuous pipe writes, starve, then drain
    for (int i = 0; i < 6; i++)
      cycle(1, 5'(1 + i), $urandom, 1, 5'(10 + i),
            1, 5'(10 + i), 32'hA000 + 32'(i));
    repeat (12) cycle(1, 5'($urandom_range(1, 31)), $urandom,
                      0, 0, 0, 0, 0);
    repeat (6) idle();

    // Set wins over clear on same register; addr-0 result discarded
    cycle(0, 0, 0, 1, 9, 0, 0, 0);
    cycle(1, 2, 32'h22, 0, 0, 1, 9, 32'h99);
    cycle(0, 0, 0, 1, 9, 0, 0, 0);
    idle();
    cycle(0, 0, 0, 0, 0, 1, 0, 32'hFFFF);
    repeat (3) idle();

    // Reset mid-operation with FIFO and pend populated
    for (int i = 0; i < 3; i++)
      cycle(1, 7, 32'h7, 1, 5'(20 + i), 1, 5'(20 + i), 32'(i));
    rst = 1'b0;
    repeat (2) cycle(1, 6, 32'h66, 1, 3, 1, 3, 32'h3);
    rst = 1'b1;
    repeat (3) idle();

    // Randomized traffic with occasional reset pulses
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 399) != 0);
      pwe = m_stall ? ($urandom_range(0, 3) == 0)
                    : ($urandom_range(0, 2) != 0);
      pa  = 5'($urandom_range(0, 31));
      pd  = $urandom;
      iss = ($urandom_range(0, 3) == 0);
      ia  = 5'($urandom_range(0, 31));
      lv  = ($urandom_range(0, 1) == 1);
      la  = 5'($urandom_range(0, 31));
      ld  = $urandom;
      cycle(pwe, pa, pd, iss, ia, lv, la, ld);
    end
    rst = 1'b1;
    repeat (4) idle();

    for (int t = 0; t < 4 && exp_q.size() > 0; t++)
      @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d records left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
